// File: rtl/neuron_mac_unit.sv
// neuron_mac_unit: sequences a weight/activation read, accumulates the dot product, adds bias, applies ReLU and saturates to Q8.8
module neuron_mac_unit #(
  parameter int N_IN   = 28,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40,
  parameter bit RELU   = 1
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     START,
  input  logic signed [DATA_W-1:0] BIAS,
  output logic        [ADDR_W-1:0] ADDR,
  output logic                     EN,
  input  logic signed [DATA_W-1:0] W_DO,
  input  logic signed [DATA_W-1:0] X_DO,
  output logic signed [DATA_W-1:0] Y,
  output logic                     Y_VALID,
  input  logic                     Y_READY,
  output logic                     BUSY
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  state_t state, state_n;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] acc, prod_x, sum, res;
  logic signed [DATA_W-1:0] bias_q, y_n;
  logic last;
  assign last = ADDR == ADDR_W'(N_IN-1);
  assign prod = W_DO * X_DO;
  assign prod_x = ACC_W'(prod);
  assign sum = acc + (ACC_W'(bias_q) <<< FRAC);
  assign res = sum >>> FRAC;
  // ReLU then clamp into the signed output range
  always_comb
    y_n = (RELU && res < 0) ? '0 :
          (res > Y_MAX) ? Y_MAX[DATA_W-1:0] :
          (res < Y_MIN) ? Y_MIN[DATA_W-1:0] : res[DATA_W-1:0];
  // state register
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) state <= IDLE;
    else state <= state_n;
  // next-state logic
  always_comb
    case (state)
      IDLE:    state_n = START ? RUN : IDLE;
      RUN:     state_n = last ? FINISH : RUN;
      FINISH:  state_n = DONE;
      default: state_n = Y_READY ? IDLE : DONE;
    endcase
  // outputs decoded from state
  always_comb BUSY = state != IDLE;
  // address/enable sequencing, accumulation and result register
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      ADDR <= '0;
      EN <= 1'b0;
      acc <= '0;
      bias_q <= '0;
      Y <= '0;
      Y_VALID <= 1'b0;
    end else
      case (state)
        IDLE:
          if (START) begin
            ADDR <= '0;
            EN <= 1'b1;
            acc <= '0;
            bias_q <= BIAS;
          end
        RUN: begin
          acc <= acc + prod_x;
          ADDR <= last ? '0 : ADDR + 1'b1;
          if (last) EN <= 1'b0;
        end
        FINISH: begin
          Y <= y_n;
          Y_VALID <= 1'b1;
        end
        default:
          if (Y_READY) Y_VALID <= 1'b0;
      endcase
endmodule

// File: tb/tb_neuron_mac_unit.sv
// tb_neuron_mac_unit: directed vectors against a RELU=1 and a RELU=0 instance sharing stimulus
module tb_neuron_mac_unit;
  typedef struct {
    string       name;
    logic [15:0] w, x, b, y1, y0;
    bit          ramp;
  } vec_t;
  logic CLK = 0, RSTN = 0, START = 0, Y_READY = 0;
  logic [15:0] BIAS = 0;
  logic [4:0] a1, a0;
  logic e1, e0, v1, v0, b1, b0;
  logic [15:0] w1, x1, w0, x0, y1, y0;
  logic [15:0] w_mem [32];
  logic [15:0] x_mem [32];
  int total = 0, bad = 0;
  vec_t vecs [9];

  neuron_mac_unit #(.RELU(1)) u1 (.CLK(CLK), .RSTN(RSTN), .START(START), .BIAS(BIAS), .ADDR(a1), .EN(e1),
    .W_DO(w1), .X_DO(x1), .Y(y1), .Y_VALID(v1), .Y_READY(Y_READY), .BUSY(b1));
  neuron_mac_unit #(.RELU(0)) u0 (.CLK(CLK), .RSTN(RSTN), .START(START), .BIAS(BIAS), .ADDR(a0), .EN(e0),
    .W_DO(w0), .X_DO(x0), .Y(y0), .Y_VALID(v0), .Y_READY(Y_READY), .BUSY(b0));

  always #5 CLK = ~CLK;

  // BRAM model: sample on negedge, DO stable at the next posedge
  always @(negedge CLK) if (e1) begin w1 <= w_mem[a1]; x1 <= x_mem[a1]; end
  always @(negedge CLK) if (e0) begin w0 <= w_mem[a0]; x0 <= x_mem[a0]; end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    for (int k = 0; k < 32; k++) begin
      w_mem[k] = v.ramp ? 16'(k) : v.w;
      x_mem[k] = v.x;
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit ok = 1;
    load(v);
    BIAS = v.b;
    @(negedge CLK); START = 1;
    @(posedge CLK); #1; START = 0; BIAS = 16'hDEAD;
    for (int k = 0; k < 28; k++) begin
      if (a1 !== 5'(k) || a0 !== 5'(k) || e1 !== 1'b1 || e0 !== 1'b1 || v1 !== 1'b0) ok = 0;
      @(posedge CLK); #1;
    end
    check({v.name, ":addr_seq"}, 32'(ok), 1);
    check({v.name, ":en_off"}, {e1, e0, a1, a0, v1, b1}, {1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1});
    @(posedge CLK); #1;
    check({v.name, ":valid_29"}, {v1, v0}, 2'b11);
    check({v.name, ":y_relu1"}, y1, v.y1);
    check({v.name, ":y_relu0"}, y0, v.y0);
    Y_READY = 1;
    @(posedge CLK); #1; Y_READY = 0;
    check({v.name, ":handshake"}, {v1, v0, b1, b0, y1, y0}, {4'b0, v.y1, v.y0});
  endtask

  initial begin
    bit ok, found;
    vecs[0] = '{"unit",      16'h0100, 16'h0100, 16'h0000, 16'h1C00, 16'h1C00, 0};
    vecs[1] = '{"sign",      16'hFF00, 16'h0100, 16'h0100, 16'h0000, 16'hE500, 0};
    vecs[2] = '{"floor_neg", 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 0};
    vecs[3] = '{"floor_pos", 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 0};
    vecs[4] = '{"sat_pos",   16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF, 0};
    vecs[5] = '{"sat_neg",   16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000, 0};
    vecs[6] = '{"bias_min",  16'h0000, 16'h1234, 16'h8000, 16'h0000, 16'h8000, 0};
    vecs[7] = '{"bias_max",  16'h0000, 16'h1234, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0};
    vecs[8] = '{"ramp",      16'h0000, 16'h0100, 16'hFF00, 16'h007A, 16'h007A, 1};

    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", {a1, e1, y1, v1, b1, a0, e0, y0, v0, b0}, '0);
    @(negedge CLK); RSTN = 1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // back-pressure: DONE holds while Y_READY low, START ignored
    load(vecs[0]);
    BIAS = 16'h0000;
    @(negedge CLK); START = 1;
    @(posedge CLK); #1; START = 0;
    repeat (29) @(posedge CLK);
    #1;
    check("bp_valid", {v1, y1}, {1'b1, 16'h1C00});
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); START = (i == 4);
      @(posedge CLK); #1; START = 0;
      if (v1 !== 1'b1 || y1 !== 16'h1C00 || b1 !== 1'b1 || e1 !== 1'b0 || v0 !== 1'b1) ok = 0;
    end
    check("bp_stable", 32'(ok), 1);
    @(negedge CLK); Y_READY = 1; START = 1;
    @(posedge CLK); #1;
    check("bp_release", {v1, b1, e1, y1}, {3'b000, 16'h1C00});
    Y_READY = 0;
    @(posedge CLK); #1; START = 0;
    check("bp_restart", {b1, e1, a1}, {2'b11, 5'd0});
    repeat (29) @(posedge CLK);
    #1;
    check("bp_second_y", {v1, y1, v0, y0}, {1'b1, 16'h1C00, 1'b1, 16'h1C00});
    Y_READY = 1;
    @(posedge CLK); #1; Y_READY = 0;

    // asynchronous reset mid-run at ADDR 13
    load(vecs[8]);
    BIAS = 16'h0100;
    @(negedge CLK); START = 1;
    @(posedge CLK); #1; START = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (a1 == 5'd13) found = 1;
      else begin @(posedge CLK); #1; end
    end
    check("rst_reach_13", 32'(found), 1);
    #2 RSTN = 0;
    #1;
    check("rst_async", {a1, e1, y1, v1, b1, a0, e0, y0, v0, b0}, '0);
    @(negedge CLK); RSTN = 1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_no_output", {v1, b1}, 2'b00);
    run_vec(vecs[8]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
